line_dispatcher: RTL and testbench
==================================

LINE_DISPATCHER -- requirements
Module: line_dispatcher

Interface
REQ-001 Parameter SIZE, default 4: board edge length; option, line_ind width SIZE bits; option_num width SIZE+1 bits.
REQ-002 Parameter DEPTH, default 64: entry queue capacity, power of two.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  load handshake; an entry transfers when both are high on a rising edge.
REQ-007 in_option, in_line_ind, in_row, in_option_num  in  SIZE, SIZE, 1, SIZE+1  one candidate option for one line, with that line's initial option count.
REQ-008 load_done  in  1  single-cycle pulse: loading finished, start solving.
REQ-009 option, line_ind, row  out  SIZE, SIZE, 1  entry issued to the solver.
REQ-010 option_num  out  SIZE+1  current live option count of the issued line, taken from the count table.
REQ-011 valid_op  out  1  single-cycle issue strobe.
REQ-012 resp_valid, put_back_to_FIFO, new_option_num  in  1, 1, SIZE+1  solver verdict for the last issued entry.
REQ-013 occupancy  out  $clog2(DEPTH)+1  number of queued entries.
REQ-014 busy, done, stuck, error  out  1 each  status flags.

Function
REQ-015 The FSM SHALL have the states LOAD, FETCH, ISSUE, WAIT and FINISH; reset enters LOAD.
REQ-016 LOAD: in_ready = (occupancy < DEPTH); each accepted entry is pushed at the tail; count_tbl[{in_row,in_line_ind}] <= in_option_num.
REQ-017 In LOAD, in_valid while the queue is full SHALL neither push nor change state; in_ready stays 0.
REQ-018 load_done in LOAD SHALL move to FETCH next cycle; a push accepted in the same cycle is kept.
REQ-019 in_ready SHALL be 0 in every state other than LOAD.
REQ-020 FETCH: an empty queue SHALL go to FINISH; otherwise the head is popped into the issue register and the state moves to ISSUE.
REQ-021 ISSUE: valid_op = 1 for exactly one cycle, with option_num = count_tbl of the entry's line; then WAIT.
REQ-022 Pop-to-valid_op latency SHALL be exactly one cycle.
REQ-023 WAIT: the block holds its outputs until resp_valid; resp_valid in any other state SHALL be ignored.
REQ-024 If the issued option_num == 1, the entry SHALL be discarded, solved_cnt incremented, and no re-push made, whatever put_back_to_FIFO says.
REQ-025 On put_back_to_FIFO = 1, the entry SHALL be re-pushed at the tail unchanged, and pass_cnt incremented.
REQ-026 On put_back_to_FIFO = 0, the entry SHALL be discarded, count_tbl[line] <= new_option_num, and pass_cnt cleared.
REQ-027 new_option_num == 0 SHALL set error (sticky) and move to FINISH.
REQ-028 A re-push SHALL never overflow, because a slot was freed by the pop.
REQ-029 Head/tail pointers SHALL wrap modulo DEPTH; occupancy is unchanged on a re-push and decrements on a discard.
REQ-030 If pass_cnt reaches occupancy with occupancy > 0, a full pass made no progress: stuck = 1 (sticky) and the FSM goes to FINISH.
REQ-031 After every verdict the FSM SHALL return to FETCH.
REQ-032 FINISH: done = 1 and held; the FSM stays there until reset.
REQ-033 busy = 1 in FETCH, ISSUE and WAIT.

Reset
REQ-034 rst_n low SHALL asynchronously clear: pointers, occupancy, pass_cnt, solved_cnt, count_tbl, valid_op, done, stuck, error, busy and in_ready; state = LOAD.
REQ-035 Reset mid-WAIT SHALL abandon the outstanding entry; a later resp_valid is ignored because the FSM is in LOAD.
REQ-036 Queue storage SHALL need no reset; a value from a previous run SHALL never be observable.

Structure
REQ-037 A shared package SHALL hold the entry struct {row, line_ind, option}, the state enum, and the line key width $clog2(2*SIZE).
REQ-038 The queue SHALL be one sub-module, circ_queue: one push port (load or re-push, muxed), one pop port, full/empty, occupancy.
REQ-039 count_tbl SHALL be a 2*SIZE-entry register array inside line_dispatcher, indexed by {row, line_ind}.

Verification
REQ-040 Load 3 entries for row 0 (num 3), then load_done; solver returns put_back = 1 every time -> after 3 issues stuck = 1, done = 1, occupancy = 3.
REQ-041 Load row 1 with options 4'b1010 and 4'b0101 (num 2); first verdict put_back = 0, new_option_num = 1 -> second issue shows option_num = 1; entry discarded; queue empties; done = 1, stuck = 0.
REQ-042 Fill DEPTH = 64 entries -> in_ready drops after the 64th; a 65th in_valid is not accepted; occupancy = 64.
REQ-043 Push 60 entries, then drop and re-push across the pointer-wrap boundary -> issue order is FIFO across the wrap, with no loss or duplication.
REQ-044 A verdict with new_option_num = 0 -> error = 1, done = 1 on the next cycle.
REQ-045 Assert rst_n low during WAIT, then release -> all outputs are zero, in_ready = 1, and a stale resp_valid has no effect.

Source files
------------

// File: rtl/line_dispatcher_pkg.sv
// Shared types for the line dispatcher: FSM states, queue entry layout and
// the count-table key derived from {row, line_ind}.
package line_dispatcher_pkg;

  // Board edge length that the entry layout is built for.
  localparam int LD_SIZE  = 4;
  // One count-table slot per line: SIZE rows-lines plus SIZE column-lines.
  localparam int LD_KEY_W = $clog2(2 * LD_SIZE);

  typedef enum logic [2:0] {
    LOAD,
    FETCH,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  typedef struct packed {
    logic               row;
    logic [LD_SIZE-1:0] line_ind;
    logic [LD_SIZE-1:0] option;
  } entry_t;

  // Count-table index of a line: the row/column flag on top of the line number.
  function automatic logic [LD_KEY_W-1:0] line_key(input logic               row,
                                                   input logic [LD_SIZE-1:0] line_ind);
    return {row, line_ind[LD_KEY_W-2:0]};
  endfunction

endpackage

// File: rtl/circ_queue.sv
// Circular FIFO of dispatcher entries with a single (muxed) push port, a
// single pop port, full/empty flags and an occupancy count.
module circ_queue
  import line_dispatcher_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_V = (PW + 1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  assign pop_data = mem[head];
  assign full     = (occupancy == DEPTH_V);
  assign empty    = (occupancy == '0);

  // Entry storage: written at the tail on every push.
  // NOTE: storage carries no reset; a slot is only read after it has been
  // written in the current run, so stale contents can never reach pop_data.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracks the net.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/line_dispatcher.sv
// Line dispatcher: loads candidate options into a FIFO, then issues them one
// at a time to a solver, re-queueing or retiring each entry on the verdict
// and tracking the live option count of every line.
module line_dispatcher
  import line_dispatcher_pkg::*;
#(
  parameter int SIZE  = LD_SIZE,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIZE-1:0]        in_option,
  input  logic [SIZE-1:0]        in_line_ind,
  input  logic                   in_row,
  input  logic [SIZE:0]          in_option_num,
  input  logic                   load_done,
  output logic [SIZE-1:0]        option,
  output logic [SIZE-1:0]        line_ind,
  output logic                   row,
  output logic [SIZE:0]          option_num,
  output logic                   valid_op,
  input  logic                   resp_valid,
  input  logic                   put_back_to_FIFO,
  input  logic [SIZE:0]          new_option_num,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   busy,
  output logic                   done,
  output logic                   stuck,
  output logic                   error
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  entry_t             head_entry;
  entry_t             load_data;
  entry_t             push_data;
  entry_t             issue_q;
  logic [SIZE:0]      num_q;
  logic [SIZE:0]      count_tbl [2*SIZE];
  logic [OCC_W-1:0]   pass_cnt;
  logic [OCC_W-1:0]   solved_cnt;
  logic               q_full;
  logic               q_empty;
  logic               push;
  logic               pop;
  logic               load_push;
  logic               verdict;
  logic               solved;
  logic               re_push;
  logic               update;
  logic               bad_count;
  logic               stuck_hit;

  // Verdict decoding. A line already down to one option is solved, so the
  // solver's put-back and new count are irrelevant for it. A zero count is
  // only meaningful on the path that writes the count back.
  assign load_push = (state == LOAD) && in_valid && !q_full;
  assign verdict   = (state == WAIT) && resp_valid;
  assign solved    = (num_q == (SIZE + 1)'(1));
  assign re_push   = verdict && !solved && put_back_to_FIFO;
  assign update    = verdict && !solved && !put_back_to_FIFO;
  assign bad_count = update && (new_option_num == '0);
  // Every queued entry was put back since the last progress: give up.
  assign stuck_hit = (state == FETCH) && !q_empty && (pass_cnt >= occupancy);
  assign pop       = (state == FETCH) && !q_empty && !stuck_hit;

  assign load_data = '{row: in_row, line_ind: in_line_ind, option: in_option};
  assign push      = load_push || re_push;
  assign push_data = load_push ? load_data : issue_q;

  assign option     = issue_q.option;
  assign line_ind   = issue_q.line_ind;
  assign row        = issue_q.row;
  assign option_num = num_q;

  circ_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (q_full),
    .empty     (q_empty),
    .occupancy (occupancy)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  // NOTE: the default assignment first keeps this purely combinational; any
  // path that left state_nxt unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (load_done) state_nxt = FETCH;
      FETCH:   state_nxt = (q_empty || stuck_hit) ? FINISH : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (resp_valid) state_nxt = bad_count ? FINISH : FETCH;
      FINISH:  state_nxt = FINISH;
      default: state_nxt = LOAD;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    valid_op = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      LOAD:        in_ready = !q_full;
      FETCH, WAIT: busy     = 1'b1;
      ISSUE: begin
        busy     = 1'b1;
        valid_op = 1'b1;
      end
      FINISH:      done     = 1'b1;
      default:     ;
    endcase
  end

  // Issue register, count table, progress counters and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q    <= '0;
      num_q      <= '0;
      pass_cnt   <= '0;
      solved_cnt <= '0;
      stuck      <= 1'b0;
      error      <= 1'b0;
      for (int i = 0; i < 2 * SIZE; i++) count_tbl[i] <= '0;
    end else begin
      if (pop) begin
        issue_q <= head_entry;
        num_q   <= count_tbl[line_key(head_entry.row, head_entry.line_ind)];
      end
      if (load_push) count_tbl[line_key(in_row, in_line_ind)] <= in_option_num;
      if (update)    count_tbl[line_key(issue_q.row, issue_q.line_ind)] <= new_option_num;
      if (verdict && solved) solved_cnt <= solved_cnt + 1'b1;
      if (re_push)                    pass_cnt <= pass_cnt + 1'b1;
      else if (update || (verdict && solved)) pass_cnt <= '0;
      if (stuck_hit) stuck <= 1'b1;
      if (bad_count) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_dispatcher.sv
// Self-checking bench for line_dispatcher: table-driven verdict vectors plus
// a FIFO scoreboard with a count-table model for the longer sequences.
module tb_line_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_option = '0;
  logic [3:0] in_line_ind = '0;
  logic       in_row = 1'b0;
  logic [4:0] in_option_num = '0;
  logic       load_done = 1'b0;
  logic [3:0] option;
  logic [3:0] line_ind;
  logic       row;
  logic [4:0] option_num;
  logic       valid_op;
  logic       resp_valid = 1'b0;
  logic       put_back_to_FIFO = 1'b0;
  logic [4:0] new_option_num = '0;
  logic [6:0] occupancy;
  logic       busy, done, stuck, error;

  typedef struct {
    logic       row;
    logic [3:0] line;
    logic [3:0] opt;
  } ent_t;

  typedef struct {
    logic       pb;
    logic [4:0] nn;
    logic [3:0] e_opt;
    logic [3:0] e_line;
    logic       e_row;
    logic [4:0] e_num;
  } vec_t;

  ent_t       sb[$];
  logic [4:0] model_tbl [8];
  vec_t       vt [3];
  int         checks = 0;
  int         errors = 0;

  line_dispatcher dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_option        (in_option),
    .in_line_ind      (in_line_ind),
    .in_row           (in_row),
    .in_option_num    (in_option_num),
    .load_done        (load_done),
    .option           (option),
    .line_ind         (line_ind),
    .row              (row),
    .option_num       (option_num),
    .valid_op         (valid_op),
    .resp_valid       (resp_valid),
    .put_back_to_FIFO (put_back_to_FIFO),
    .new_option_num   (new_option_num),
    .occupancy        (occupancy),
    .busy             (busy),
    .done             (done),
    .stuck            (stuck),
    .error            (error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  function automatic int tkey(input logic r, input logic [3:0] l);
    return int'({r, l[1:0]});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; load_done = 1'b0; resp_valid = 1'b0;
    put_back_to_FIFO = 1'b0; new_option_num = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.delete();
    for (int i = 0; i < 8; i++) model_tbl[i] = '0;
  endtask

  task automatic load_entry(input logic r, input logic [3:0] l, input logic [3:0] o,
                            input logic [4:0] n);
    check("load_in_ready", in_ready, 1);
    in_valid = 1'b1; in_row = r; in_line_ind = l; in_option = o; in_option_num = n;
    @(negedge clk);
    in_valid = 1'b0;
    sb.push_back('{row: r, line: l, opt: o});
    model_tbl[tkey(r, l)] = n;
  endtask

  task automatic start();
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid_op === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: valid_op stayed low for 20 cycles, expected a pulse");
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done stayed low for 20 cycles, expected 1");
    end
  endtask

  // Called in the ISSUE cycle: moves to WAIT, then returns the verdict.
  task automatic respond(input logic pb, input logic [4:0] nn);
    @(negedge clk);
    check("valid_op_single", valid_op, 0);
    check("busy_wait", busy, 1);
    resp_valid = 1'b1; put_back_to_FIFO = pb; new_option_num = nn;
    @(negedge clk);
    resp_valid = 1'b0; put_back_to_FIFO = 1'b0; new_option_num = '0;
  endtask

  task automatic issue_and_respond(input logic pb, input logic [4:0] nn);
    bit         ok;
    ent_t       e;
    logic [4:0] en;
    wait_issue(ok);
    if (!ok) return;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_extra_issue: option %0h issued, expected none", option);
      return;
    end
    e  = sb.pop_front();
    en = model_tbl[tkey(e.row, e.line)];
    check("issue_option", option, e.opt);
    check("issue_line", line_ind, e.line);
    check("issue_row", row, e.row);
    check("issue_num", option_num, en);
    check("issue_occ", occupancy, sb.size());
    respond(pb, nn);
    if (en == 5'd1)  ;
    else if (pb)     sb.push_back(e);
    else             model_tbl[tkey(e.row, e.line)] = nn;
  endtask

  initial begin
    bit ok;

    // Reset state.
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_valid_op", valid_op, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {done, stuck, error}, 0);
    check("rst_occ", occupancy, 0);
    check("rst_issue", {row, line_ind, option, option_num}, 0);

    // Three entries that are always put back: stuck after one full pass.
    for (int i = 0; i < 3; i++) load_entry(1'b0, 4'(i), 4'(1 << i), 5'd3);
    start();
    for (int i = 0; i < 3; i++) issue_and_respond(1'b1, 5'd3);
    wait_done();
    check("stuck_flag", stuck, 1);
    check("stuck_done", done, 1);
    check("stuck_occ", occupancy, 3);
    check("stuck_error", error, 0);
    check("stuck_busy", busy, 0);

    // Table-driven: solved line, count update to 1, then solved on reissue.
    do_reset();
    vt[0] = '{pb: 1'b0, nn: 5'd5, e_opt: 4'b0011, e_line: 4'd0, e_row: 1'b0, e_num: 5'd1};
    vt[1] = '{pb: 1'b0, nn: 5'd1, e_opt: 4'b1010, e_line: 4'd3, e_row: 1'b1, e_num: 5'd2};
    vt[2] = '{pb: 1'b1, nn: 5'd2, e_opt: 4'b0101, e_line: 4'd3, e_row: 1'b1, e_num: 5'd1};
    load_entry(1'b0, 4'd0, 4'b0011, 5'd1);
    load_entry(1'b1, 4'd3, 4'b1010, 5'd2);
    load_entry(1'b1, 4'd3, 4'b0101, 5'd2);
    start();
    for (int i = 0; i < 3; i++) begin
      wait_issue(ok);
      if (!ok) break;
      check("vec_option", option, vt[i].e_opt);
      check("vec_line", line_ind, vt[i].e_line);
      check("vec_row", row, vt[i].e_row);
      check("vec_num", option_num, vt[i].e_num);
      respond(vt[i].pb, vt[i].nn);
    end
    wait_done();
    check("vec_stuck", stuck, 0);
    check("vec_error", error, 0);
    check("vec_occ", occupancy, 0);

    // Fill the queue to capacity; a 65th offer must be refused.
    do_reset();
    for (int i = 0; i < 64; i++) load_entry(1'(i >> 2), 4'(i % 4), 4'(i), 5'd2);
    check("full_in_ready", in_ready, 0);
    check("full_occ", occupancy, 64);
    in_valid = 1'b1; in_option = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    check("full_occ_after", occupancy, 64);
    check("full_still_load", {busy, done}, 0);
    check("full_in_ready_after", in_ready, 0);

    // Pointer wrap: 60 entries, mixed re-push/discard, then drain.
    do_reset();
    for (int i = 0; i < 60; i++) load_entry(1'(i >> 2), 4'(i % 4), 4'(i), 5'd2);
    start();
    for (int k = 0; k < 70; k++) issue_and_respond((k % 5) != 0, 5'(2 + k % 3));
    for (int g = 0; g < 80 && sb.size() > 0; g++) issue_and_respond(1'b0, 5'd3);
    wait_done();
    check("wrap_occ", occupancy, 0);
    check("wrap_flags", {stuck, error}, 0);

    // Zero count from the solver: error and finish on the next cycle.
    do_reset();
    load_entry(1'b0, 4'd1, 4'b0110, 5'd3);
    start();
    wait_issue(ok);
    respond(1'b0, 5'd0);
    check("err_flag", error, 1);
    check("err_done", done, 1);
    check("err_busy", busy, 0);
    check("err_stuck", stuck, 0);

    // Reset while waiting for a verdict; a stale verdict afterwards is ignored.
    do_reset();
    load_entry(1'b1, 4'd2, 4'b1100, 5'd3);
    load_entry(1'b0, 4'd2, 4'b0011, 5'd3);
    start();
    wait_issue(ok);
    @(negedge clk);
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", {valid_op, busy, done, stuck, error}, 0);
    check("arst_occ", occupancy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_issue", {row, line_ind, option, option_num}, 0);
    check("post_rst_in_ready", in_ready, 1);
    resp_valid = 1'b1; put_back_to_FIFO = 1'b1; new_option_num = 5'd0;
    @(negedge clk);
    resp_valid = 1'b0; put_back_to_FIFO = 1'b0;
    repeat (2) @(negedge clk);
    check("stale_occ", occupancy, 0);
    check("stale_status", {valid_op, busy, done, stuck, error}, 0);
    check("stale_in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
